// File: rtl/smvm_frame_tx.sv
// SMVM input-stream frame transmitter: loads a dense vector and row-major matrix,
// compresses the matrix into a row-marked sparse entry list and emits one gapless frame.
module smvm_frame_tx #(
  parameter int MAX_ROWS = 16,
  parameter int MAX_COLS = 16,
  parameter int MAX_ENT  = 64,
  parameter int K        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_load,
  input  logic [7:0] cfg_rows,
  input  logic [7:0] cfg_cols,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       tx_start,
  output logic       loaded,
  output logic       busy,
  output logic       err,
  output logic       tx_valid,
  output logic [7:0] tx_val,
  output logic [2:0] tx_col,
  output logic       tx_ipv,
  output logic       done
);

  localparam int IW = $clog2(MAX_ENT + 1);
  localparam int EW = $clog2(MAX_ENT);
  localparam int CW = $clog2(MAX_COLS);

  typedef enum logic [3:0] {
    IDLE, LD_VEC, LD_MAT, RDY, TX_ROWS, TX_COLS, TX_VEC, TX_VAL, TX_IDX
  } state_t;

  // Field order makes a 12-bit value N cast directly to {val=N[11:4], ipv=N[3], col=N[2:0]}.
  typedef struct packed {
    logic [7:0] val;
    logic       ipv;
    logic [2:0] col;
  } beat_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      rows_q, cols_q, row_q, col_q;
  logic            row_nz_q;
  logic [IW-1:0]   ent_cnt;
  beat_t           beat_d;
  logic            valid_d, done_d;

  logic [7:0]      vec_mem [MAX_COLS];
  logic [7:0]      ent_val [MAX_ENT];
  logic [7:0]      ent_col [MAX_ENT];
  logic            ent_ipv [MAX_ENT];

  logic hs, nz, row_end, mat_last, append, ent_full, cfg_ok, cfg_take;
  int   p_cnt;

  assign s_ready = (state_q == LD_VEC) || (state_q == LD_MAT);
  assign busy    = s_ready || (state_q == TX_ROWS) || (state_q == TX_COLS) ||
                   (state_q == TX_VEC) || (state_q == TX_VAL) || (state_q == TX_IDX);
  assign loaded  = (state_q == RDY);

  assign hs       = s_valid && s_ready;
  assign nz       = (s_data != 8'd0);
  assign row_end  = (int'(col_q) == int'(cols_q) - 1);
  assign mat_last = row_end && (int'(row_q) == int'(rows_q) - 1);
  // A row without any nonzero still emits a marker entry so the receiver sees the row boundary.
  assign append   = nz || (row_end && !row_nz_q);
  assign ent_full = (int'(ent_cnt) == MAX_ENT);
  assign cfg_ok   = (cfg_rows != 8'd0) && (int'(cfg_rows) <= MAX_ROWS) &&
                    (cfg_cols != 8'd0) && (int'(cfg_cols) <= MAX_COLS);
  assign cfg_take = cfg_load && ((state_q == IDLE) || (state_q == RDY));
  assign p_cnt    = ((int'(ent_cnt) + K - 1) / K) * K;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    beat_d  = '0;

    unique case (state_q)
      IDLE, RDY: begin
        if (cfg_take && cfg_ok) begin
          state_d = LD_VEC;
          idx_d   = '0;
        end else if (state_q == RDY && tx_start && !cfg_load) begin
          state_d = TX_ROWS;
          idx_d   = '0;
        end
      end
      LD_VEC: if (hs) begin
        if (int'(idx_q) == int'(cols_q) - 1) begin
          state_d = LD_MAT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      LD_MAT:  if (hs && mat_last) state_d = RDY;
      TX_ROWS: state_d = TX_COLS;
      TX_COLS: begin
        state_d = TX_VEC;
        idx_d   = '0;
      end
      TX_VEC: begin
        if (int'(idx_q) == int'(cols_q) - 1) begin
          state_d = TX_VAL;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      TX_VAL: state_d = TX_IDX;
      TX_IDX: begin
        if (int'(idx_q) == p_cnt - 1) begin
          state_d = RDY;
          done_d  = 1'b1;
        end else begin
          state_d = TX_VAL;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed for the beat that the next state presents, then registered.
    unique case (state_d)
      TX_ROWS: begin
        valid_d = 1'b1;
        beat_d  = beat_t'({4'b0, rows_q});
      end
      TX_COLS: begin
        valid_d = 1'b1;
        beat_d  = beat_t'({4'b0, cols_q});
      end
      TX_VEC: begin
        valid_d    = 1'b1;
        beat_d.val = vec_mem[idx_d[CW-1:0]];
      end
      TX_VAL: begin
        valid_d = 1'b1;
        if (idx_d < ent_cnt) begin
          beat_d.val = ent_val[idx_d[EW-1:0]];
          beat_d.ipv = ent_ipv[idx_d[EW-1:0]];
        end
      end
      TX_IDX: begin
        valid_d = 1'b1;
        if (idx_d < ent_cnt) beat_d = beat_t'({4'b0, ent_col[idx_d[EW-1:0]]});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      row_nz_q <= 1'b0;
      ent_cnt  <= '0;
      err      <= 1'b0;
      tx_valid <= 1'b0;
      tx_val   <= '0;
      tx_ipv   <= 1'b0;
      tx_col   <= '0;
      done     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= state_d;
      idx_q    <= idx_d;
      tx_valid <= valid_d;
      {tx_val, tx_ipv, tx_col} <= beat_d;
      done     <= done_d;

      if (cfg_take) begin
        if (cfg_ok) begin
          rows_q   <= cfg_rows;
          cols_q   <= cfg_cols;
          row_q    <= '0;
          col_q    <= '0;
          row_nz_q <= 1'b0;
          ent_cnt  <= '0;
          err      <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end

      if (state_q == LD_MAT && hs) begin
        if (append) begin
          if (ent_full) err <= 1'b1;
          else          ent_cnt <= ent_cnt + 1'b1;
        end
        if (row_end) begin
          col_q    <= '0;
          row_q    <= row_q + 8'd1;
          row_nz_q <= 1'b0;
        end else begin
          col_q    <= col_q + 8'd1;
          row_nz_q <= row_nz_q || nz;
        end
      end
    end
  end

  // NOTE: buffer memories carry no reset; loaded data is only read after a complete load.
  always_ff @(posedge clk) begin
    if (state_q == LD_VEC && hs) vec_mem[idx_q[CW-1:0]] <= s_data;
    if (state_q == LD_MAT && hs && append && !ent_full) begin
      ent_val[ent_cnt[EW-1:0]] <= s_data;
      ent_col[ent_cnt[EW-1:0]] <= nz ? col_q : 8'd0;
      ent_ipv[ent_cnt[EW-1:0]] <= nz ? !row_nz_q : 1'b1;
    end
  end

endmodule

// File: tb/tb_smvm_frame_tx.sv
// Self-checking bench for smvm_frame_tx: table-driven config and basic-frame vectors,
// plus directed load/transmit sequences checked against a small reference model.
module tb_smvm_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_rows = '0;
  logic [7:0] cfg_cols = '0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       tx_start = 1'b0;
  logic       s_ready, loaded, busy, err, tx_valid, tx_ipv, done;
  logic [7:0] tx_val;
  logic [2:0] tx_col;

  smvm_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .tx_start(tx_start),
    .loaded(loaded), .busy(busy), .err(err), .tx_valid(tx_valid), .tx_val(tx_val),
    .tx_col(tx_col), .tx_ipv(tx_ipv), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] rows;
    logic [7:0] cols;
    logic       exp_err;
    logic       exp_busy;
  } cfg_vec_t;

  typedef struct {
    logic [7:0] val;
    logic       ipv;
    logic [2:0] col;
  } beat_rec_t;

  cfg_vec_t   cfg_tab [5];
  beat_rec_t  basic_tab [13];

  int          vec_m [16];
  int          mat_m [16][16];
  logic [7:0]  stream [$];
  logic [11:0] exp_q [$];
  logic [11:0] got [$];
  logic [11:0] first_frame [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      vec_m[i] = 0;
      for (int j = 0; j < 16; j++) mat_m[i][j] = 0;
    end
  endtask

  // Reference model: builds the input stream and the expected frame beats {val,ipv,col}.
  task automatic build_model(input int rows, input int cols);
    int ev [$];
    int ec [$];
    bit ei [$];
    bit seen;
    exp_q.delete();
    stream.delete();
    exp_q.push_back(12'(rows));
    exp_q.push_back(12'(cols));
    for (int i = 0; i < cols; i++) begin
      stream.push_back(8'(vec_m[i]));
      exp_q.push_back({8'(vec_m[i]), 4'b0});
    end
    for (int r = 0; r < rows; r++) begin
      seen = 1'b0;
      for (int c = 0; c < cols; c++) begin
        stream.push_back(8'(mat_m[r][c]));
        if (mat_m[r][c] != 0) begin
          if (ev.size() < 64) begin
            ev.push_back(mat_m[r][c]); ec.push_back(c); ei.push_back(!seen);
          end
          seen = 1'b1;
        end
      end
      if (!seen && ev.size() < 64) begin
        ev.push_back(0); ec.push_back(0); ei.push_back(1'b1);
      end
    end
    while (ev.size() % 4 != 0) begin
      ev.push_back(0); ec.push_back(0); ei.push_back(1'b0);
    end
    for (int j = 0; j < ev.size(); j++) begin
      exp_q.push_back({8'(ev[j]), ei[j], 3'b0});
      exp_q.push_back(12'(ec[j]));
    end
  endtask

  task automatic pulse_cfg(input int rows, input int cols, input bit with_tx);
    cfg_rows = 8'(rows);
    cfg_cols = 8'(cols);
    cfg_load = 1'b1;
    tx_start = with_tx;
    @(negedge clk);
    cfg_load = 1'b0;
    tx_start = 1'b0;
  endtask

  task automatic send_stream(input string name, input bit bubbles);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    while (i < stream.size() && guard < 4000) begin
      if (bubbles && $urandom_range(0, 1) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = stream[i];
      end
      acc = s_valid && s_ready;
      @(negedge clk);
      if (acc) i++;
      guard++;
    end
    s_valid = 1'b0;
    check({name, " load completes"}, 32'(i), 32'(stream.size()));
    check({name, " loaded after load"}, 32'(loaded), 32'd1);
    check({name, " s_ready low after load"}, 32'(s_ready), 32'd0);
  endtask

  task automatic start_tx();
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic capture_frame(input string name);
    int cyc = 0;
    bit gap = 1'b0;
    got.delete();
    start_tx();
    check({name, " first beat latency"}, 32'(tx_valid), 32'd1);
    while (!done && cyc < 400) begin
      if (tx_valid) got.push_back({tx_val, tx_ipv, tx_col});
      else          gap = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({name, " done pulse"}, 32'(done), 32'd1);
    check({name, " tx_valid low at done"}, 32'(tx_valid), 32'd0);
    check({name, " gapless"}, 32'(gap), 32'd0);
    check({name, " back in RDY"}, 32'(loaded), 32'd1);
    @(negedge clk);
    check({name, " done one cycle"}, 32'(done), 32'd0);
  endtask

  task automatic compare_model(input string name, input int exp_len);
    int bad = -1;
    check({name, " frame length"}, 32'(got.size()), 32'(exp_len));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (bad < 0 && (k >= got.size() || got[k] !== exp_q[k])) bad = k;
    end
    if (bad >= 0 && bad < got.size())
      $display("  %s beat %0d got %h want %h", name, bad, got[bad], exp_q[bad]);
    check({name, " first differing beat"}, 32'(bad), 32'hFFFF_FFFF);
  endtask

  task automatic compare_table(input string name);
    check({name, " frame length"}, 32'(got.size()), 32'd13);
    for (int k = 0; k < 13; k++) begin
      check($sformatf("%s beat %0d", name, k), 32'(got[k]),
            32'({basic_tab[k].val, basic_tab[k].ipv, basic_tab[k].col}));
    end
  endtask

  task automatic setup_basic();
    clear_model();
    vec_m[0] = 1; vec_m[1] = 2; vec_m[2] = 3;
    mat_m[0][1] = 5;
    build_model(2, 3);
  endtask

  initial begin
    cfg_tab[0] = '{8'd0,   8'd3,   1'b1, 1'b0};
    cfg_tab[1] = '{8'd3,   8'd0,   1'b1, 1'b0};
    cfg_tab[2] = '{8'd17,  8'd1,   1'b1, 1'b0};
    cfg_tab[3] = '{8'd1,   8'd17,  1'b1, 1'b0};
    cfg_tab[4] = '{8'd255, 8'd255, 1'b1, 1'b0};

    basic_tab[0]  = '{8'd0, 1'b0, 3'd2};
    basic_tab[1]  = '{8'd0, 1'b0, 3'd3};
    basic_tab[2]  = '{8'd1, 1'b0, 3'd0};
    basic_tab[3]  = '{8'd2, 1'b0, 3'd0};
    basic_tab[4]  = '{8'd3, 1'b0, 3'd0};
    basic_tab[5]  = '{8'd5, 1'b1, 3'd0};
    basic_tab[6]  = '{8'd0, 1'b0, 3'd1};
    basic_tab[7]  = '{8'd0, 1'b1, 3'd0};
    basic_tab[8]  = '{8'd0, 1'b0, 3'd0};
    basic_tab[9]  = '{8'd0, 1'b0, 3'd0};
    basic_tab[10] = '{8'd0, 1'b0, 3'd0};
    basic_tab[11] = '{8'd0, 1'b0, 3'd0};
    basic_tab[12] = '{8'd0, 1'b0, 3'd0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset outputs", 32'({tx_valid, s_ready, busy, loaded, err, done}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle outputs", 32'({tx_valid, s_ready, busy, loaded, err, done}), 32'd0);

    // Config validation table
    for (int i = 0; i < 5; i++) begin
      pulse_cfg(int'(cfg_tab[i].rows), int'(cfg_tab[i].cols), 1'b0);
      check($sformatf("cfg %0d err", i), 32'(err), 32'(cfg_tab[i].exp_err));
      check($sformatf("cfg %0d busy", i), 32'(busy), 32'(cfg_tab[i].exp_busy));
      check($sformatf("cfg %0d s_ready", i), 32'(s_ready), 32'd0);
    end

    // Basic frame, continuous load
    setup_basic();
    pulse_cfg(2, 3, 1'b0);
    check("basic err cleared", 32'(err), 32'd0);
    check("basic busy in load", 32'(busy), 32'd1);
    send_stream("basic", 1'b0);
    capture_frame("basic");
    compare_table("basic");

    // Same frame with bubbles in the load
    pulse_cfg(2, 3, 1'b0);
    send_stream("bubbles", 1'b1);
    capture_frame("bubbles");
    compare_table("bubbles");

    // Encoding and sign
    clear_model();
    for (int i = 0; i < 16; i++) vec_m[i] = i + 1;
    mat_m[0][9] = -3;
    build_model(1, 16);
    pulse_cfg(1, 16, 1'b0);
    send_stream("encode", 1'b0);
    capture_frame("encode");
    compare_model("encode", 26);
    check("encode cols header", 32'(got[1]), 32'h010);
    check("encode VAL beat", 32'(got[18]), 32'hFD8);
    check("encode IDX beat", 32'(got[19]), 32'h009);

    // Exact multiple of the group size
    clear_model();
    for (int i = 0; i < 4; i++) vec_m[i] = 1;
    mat_m[0][0] = 7; mat_m[0][1] = -1; mat_m[0][2] = 2; mat_m[0][3] = 4;
    build_model(1, 4);
    pulse_cfg(1, 4, 1'b0);
    send_stream("exact", 1'b0);
    capture_frame("exact");
    compare_model("exact", 14);
    check("exact ipv pattern", 32'({got[6][3], got[8][3], got[10][3], got[12][3]}), 32'b1000);

    // Reset in the middle of TX_VEC
    start_tx();
    repeat (2) @(negedge clk);
    check("mid-frame tx_valid before reset", 32'(tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset drops tx_valid", 32'(tx_valid), 32'd0);
    check("reset drops loaded", 32'(loaded), 32'd0);
    check("reset drops busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset idle", 32'({loaded, busy, tx_valid}), 32'd0);

    // Entry overflow
    clear_model();
    for (int i = 0; i < 16; i++) begin
      vec_m[i] = i + 1;
      for (int j = 0; j < 16; j++) mat_m[i][j] = (i * 16 + j) % 120 + 1;
    end
    build_model(16, 16);
    pulse_cfg(16, 16, 1'b0);
    send_stream("overflow", 1'b0);
    check("overflow err", 32'(err), 32'd1);
    capture_frame("overflow");
    compare_model("overflow", 146);

    // cfg_load and tx_start together in RDY: the load wins
    setup_basic();
    pulse_cfg(2, 3, 1'b1);
    check("cfg wins busy", 32'(busy), 32'd1);
    check("cfg wins s_ready", 32'(s_ready), 32'd1);
    check("cfg wins no frame", 32'(tx_valid), 32'd0);
    check("cfg wins err cleared", 32'(err), 32'd0);
    send_stream("reload", 1'b0);

    // Retransmit twice
    capture_frame("retx1");
    compare_table("retx1");
    first_frame = got;
    capture_frame("retx2");
    compare_table("retx2");
    check("retx frames identical", 32'(first_frame == got), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
